// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and the pipeline-control FSM state.
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pipectrl_state_t;

endpackage

// File: rtl/pipeline_control_hazard_unit.sv
// Load-use comparator: a load in EX whose destination feeds an ID-stage source.
module hazard_unit (
  input  logic       idex_dREN,
  input  logic [4:0] idex_wsel,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       load_use
);

  // r0 is hard-wired, so a load targeting it never creates a dependency
  assign load_use = idex_dREN && (idex_wsel != '0) &&
                    ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_control.sv
// Central sequencer for the five-stage pipeline latches and PC write enable.
// Optional performance counters are built when PIPECTRL_PERF_EN is defined.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int unsigned MISS_LIMIT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic        branch_taken,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_wsel,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        wb_halt,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        idex_enable,
  output logic        exmem_enable,
  output logic        memwb_enable,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halted,
`ifdef PIPECTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_timeout
);

  localparam int unsigned CW = $clog2(MISS_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MISS_LIMIT);

  pipectrl_state_t state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            halted_q, halted_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            load_use;
  logic            miss;
  logic            branch_flush;

  hazard_unit u_hazard (
    .idex_dREN (idex_dREN),
    .idex_wsel (idex_wsel),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .load_use  (load_use)
  );

  always_comb begin
    state_d      = state_q;
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    idex_enable  = 1'b0;
    exmem_enable = 1'b0;
    memwb_enable = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    branch_flush = 1'b0;
    // once waiting, only dhit matters; mem_req is held by the frozen exmem latch
    miss = (state_q == DWAIT) ? !dhit : (mem_req && !dhit);

    if (state_q == HALT) begin
      state_d = HALT;
    end else if (wb_halt) begin
      state_d = HALT;
    end else if (miss) begin
      state_d      = DWAIT;
      memwb_enable = 1'b1;
      memwb_flush  = 1'b1;
    end else begin
      state_d      = RUN;
      pc_enable    = 1'b1;
      ifid_enable  = 1'b1;
      idex_enable  = 1'b1;
      exmem_enable = 1'b1;
      memwb_enable = 1'b1;
      if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        idex_flush  = 1'b1;
      end else if (!ihit) begin
        pc_enable  = 1'b0;
        ifid_flush = 1'b1;
      end
    end

    if (RST) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_flush  = 1'b1;
      branch_flush = 1'b0;
    end

    // counts every cycle that ends in DWAIT, including the entry cycle
    if (state_d == DWAIT)
      wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    else
      wait_cnt_d = '0;
    mem_timeout_d = mem_timeout_q || (wait_cnt_d == LIMIT);
    halted_d      = halted_q || (state_d == HALT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;

`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'b0, (state_q != HALT) && !pc_enable};
    flush_count_d  = flush_count_q + {31'b0, branch_flush};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control (MISS_LIMIT overridden to 4).
module tb_pipeline_control;

  logic       CLK;
  logic       RST;
  logic       ihit, dhit, mem_req, branch_taken, idex_dREN, wb_halt;
  logic [4:0] idex_wsel, ifid_rs, ifid_rt;
  logic       pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       halted, mem_timeout;
`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_control #(.MISS_LIMIT(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_req      (mem_req),
    .branch_taken (branch_taken),
    .idex_dREN    (idex_dREN),
    .idex_wsel    (idex_wsel),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .wb_halt      (wb_halt),
    .pc_enable    (pc_enable),
    .ifid_enable  (ifid_enable),
    .idex_enable  (idex_enable),
    .exmem_enable (exmem_enable),
    .memwb_enable (memwb_enable),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
`ifdef PIPECTRL_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .mem_timeout  (mem_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc, ifid/idex/exmem/memwb enables, ifid/idex/exmem/memwb flushes, halted, mem_timeout}
  logic [10:0] obs;
  assign obs = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, mem_timeout};

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [10:0] ex(input logic pc, input logic [3:0] en,
                                     input logic [3:0] fl, input logic h, input logic t);
    return {pc, en, fl, h, t};
  endfunction

  task automatic step(input string tag, input logic [10:0] expv);
    exp_t e;
    e.tag = tag;
    e.val = expv;
    sb.push_back(e);
    @(negedge CLK);
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
    idex_dREN = 1'b0; idex_wsel = '0; ifid_rs = '0; ifid_rt = '0; wb_halt = 1'b0;
  endtask

  logic [10:0] RUNX, MISSX, MISST, LUX, BRX, RSTX;

  initial begin
    RUNX  = ex(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    MISSX = ex(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
    MISST = ex(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1);
    LUX   = ex(1'b0, 4'b0111, 4'b0100, 1'b0, 1'b0);
    BRX   = ex(1'b1, 4'b1111, 4'b1110, 1'b0, 1'b0);
    RSTX  = ex(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);

    RST = 1'b1;
    idle();
    step("reset", RSTX);
    RST = 1'b0;
    step("run", RUNX);

    // D-miss of three cycles; ihit ignored while frozen
    mem_req = 1'b1; ihit = 1'b0;
    step("dmiss_c1", MISSX);
    step("dmiss_c2", MISSX);
    step("dmiss_c3", MISSX);
    dhit = 1'b1; ihit = 1'b1;
    step("dmiss_done", RUNX);
    idle();

    idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rt = 5'd5;
    step("lu_rt", LUX);
    idex_wsel = 5'd0; ifid_rt = 5'd0;
    step("lu_wsel0", RUNX);
    idex_wsel = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd3;
    step("lu_rs", LUX);
    idex_dREN = 1'b0;
    step("lu_no_load", RUNX);
    idle();

    ihit = 1'b0;
    step("ifetch_miss", ex(1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0));

    branch_taken = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rt = 5'd5;
    step("br_over_lu", BRX);
    mem_req = 1'b1; dhit = 1'b1;
    step("br_dhit", BRX);
    dhit = 1'b0;
    step("br_miss", MISSX);
    dhit = 1'b1;
    step("br_after_dwait", BRX);
    idle();

    // load-use held by the freeze, resolved once dhit arrives
    mem_req = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rt = 5'd5;
    step("lu_miss_c1", MISSX);
    step("lu_miss_c2", MISSX);
    step("lu_miss_c3", MISSX);
    dhit = 1'b1;
    step("lu_after_miss", LUX);
    idle();

    // a further short miss must not time out if the counter was cleared
    mem_req = 1'b1;
    step("clr_c1", MISSX);
    step("clr_c2", MISSX);
    step("clr_c3", MISSX);
    dhit = 1'b1;
    step("clr_done", RUNX);
    idle();

    mem_req = 1'b1;
    step("to_c1", MISSX);
    step("to_c2", MISSX);
    step("to_c3", MISSX);
    step("to_c4", MISSX);
    step("to_c5", MISST);
    step("to_c6", MISST);
    dhit = 1'b1;
    step("to_done", ex(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1));
    idle();

    wb_halt = 1'b1;
    step("halt_enter", ex(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1));
    wb_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0];
      branch_taken = i[1];
      step("halt_hold", ex(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1));
    end
    idle();

    RST = 1'b1;
    step("reset2", RSTX);
    RST = 1'b0;
    step("after_reset", RUNX);

    mem_req = 1'b1;
    step("pre_halt_miss", MISSX);
    wb_halt = 1'b1;
    step("halt_over_dwait", ex(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
    wb_halt = 1'b0; dhit = 1'b1;
    step("halted_after_dwait", ex(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
